// File: rtl/bit_ctrl_pkg.sv
// Shared definitions for the bit_ctrl block.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Contents: 3-bit opcode encodings, status-byte bit positions, popcount helper.
package bit_ctrl_pkg;

    localparam logic [2:0] OP_LOAD = 3'd0;
    localparam logic [2:0] OP_SET  = 3'd1;
    localparam logic [2:0] OP_CLR  = 3'd2;
    localparam logic [2:0] OP_TOG  = 3'd3;
    localparam logic [2:0] OP_ROL  = 3'd4;
    localparam logic [2:0] OP_ROR  = 3'd5;
    localparam logic [2:0] OP_AND  = 3'd6;
    localparam logic [2:0] OP_XOR  = 3'd7;

    // Status byte layout: {Z, P, T, 0, CNT[3:0]}
    localparam int ST_Z   = 7;
    localparam int ST_P   = 6;
    localparam int ST_T   = 5;
    localparam int ST_CNT = 0;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/bit_ctrl_alu.sv
// Bit-manipulation datapath: computes the next register value and the tested bit.
// Latency: purely combinational, zero cycles.
// Backpressure: none; result is valid whenever inputs are.
// Ports: r (current R), d (operand), op, idx -> r_next, tested_bit (= r[idx]).
module bit_ctrl_alu
    import bit_ctrl_pkg::*;
(
    input  logic [7:0] r,
    input  logic [7:0] d,
    input  logic [2:0] op,
    input  logic [2:0] idx,
    output logic [7:0] r_next,
    output logic       tested_bit
);

    logic [7:0]  one_hot;
    logic [15:0] dbl_l;
    logic [15:0] dbl_r;

    always_comb begin
        one_hot = 8'd1 << idx;
        // Rotation by shifting a doubled copy: the wrapped bits fall out of
        // the neighbouring half, so idx=0 naturally leaves R unchanged.
        dbl_l   = {r, r} << idx;
        dbl_r   = {r, r} >> idx;
        r_next  = r;
        unique case (op)
            OP_LOAD: r_next = d;
            OP_SET:  r_next = r | one_hot;
            OP_CLR:  r_next = r & ~one_hot;
            OP_TOG:  r_next = r ^ one_hot;
            OP_ROL:  r_next = dbl_l[15:8];
            OP_ROR:  r_next = dbl_r[7:0];
            OP_AND:  r_next = r & d;
            OP_XOR:  r_next = r ^ d;
            default: r_next = r;
        endcase
    end

    assign tested_bit = r[idx];

endmodule

// File: rtl/bit_ctrl.sv
// Strobed 8-bit bit-manipulation register with a status view (popcount/parity/zero/tested bit).
// Latency: a command fires on the clock edge where the strobe first rises; new R is visible right after it.
// Backpressure: none; a held strobe executes once, re-arm needs strobe low for at least one clock.
// Ports: clk, rst_n (async active-low), ena, ui_in {strobe, op[2:0], view_sel, idx[2:0]},
//        uio_in (operand D), uo_out (R or status), uio_out/uio_oe tied low.
module bit_ctrl
    import bit_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    output logic [7:0] uo_out
);

    logic       strobe;
    logic [2:0] op;
    logic       view_sel;
    logic [2:0] idx;

    logic [7:0] r_q;
    logic       stb_q;
    logic       t_q;

    logic       fire;
    logic [7:0] r_next;
    logic       tested_bit;
    logic [7:0] status;

    assign strobe   = ui_in[7];
    assign op       = ui_in[6:4];
    assign view_sel = ui_in[3];
    assign idx      = ui_in[2:0];

    // stb_q only advances while enabled, so raising ena with strobe already
    // high fires only if the strobe was seen low the last time we were enabled.
    assign fire = ena & strobe & ~stb_q;

    bit_ctrl_alu u_alu (
        .r          (r_q),
        .d          (uio_in),
        .op         (op),
        .idx        (idx),
        .r_next     (r_next),
        .tested_bit (tested_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= 8'h00;
            stb_q <= 1'b0;
            t_q   <= 1'b0;
        end else if (ena) begin
            stb_q <= strobe;
            if (fire) begin
                r_q <= r_next;
                t_q <= tested_bit;
            end
        end
    end

    always_comb begin
        status               = 8'h00;
        status[ST_Z]         = (r_q == 8'h00);
        status[ST_P]         = ^r_q;
        status[ST_T]         = t_q;
        status[ST_CNT +: 4]  = popcount8(r_q);
    end

    assign uo_out  = view_sel ? status : r_q;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_bit_ctrl.sv
module tb_bit_ctrl;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic [7:0] uo_out;

    int vectors;
    int miscompares;

    bit_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe),
        .uo_out  (uo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] op;
        logic [2:0] idx;
        logic [7:0] d;
        logic [7:0] exp_r;
        logic [7:0] exp_st;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Drive inputs at the falling edge so they are stable around the rising edge.
    task automatic pulse_cmd(input logic [2:0] op, input logic [2:0] idx, input logic [7:0] d);
        @(negedge clk);
        uio_in = d;
        ui_in  = {1'b1, op, 1'b0, idx};
        @(negedge clk);
        ui_in[7] = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_views(output logic [7:0] rv, output logic [7:0] sv);
        ui_in[3] = 1'b0;
        #1 rv = uo_out;
        ui_in[3] = 1'b1;
        #1 sv = uo_out;
        ui_in[3] = 1'b0;
        #1;
    endtask

    // ---------------- reference model (bit-list arithmetic) ----------------
    function automatic int bit_of(input int v, input int i);
        return (v / (1 << i)) % 2;
    endfunction

    function automatic int model_next(input int r, input int op, input int idx, input int d);
        int res;
        res = 0;
        case (op)
            0: res = d;
            1: res = (bit_of(r, idx) == 1) ? r : r + (1 << idx);
            2: res = (bit_of(r, idx) == 1) ? r - (1 << idx) : r;
            3: res = (bit_of(r, idx) == 1) ? r - (1 << idx) : r + (1 << idx);
            4: for (int i = 0; i < 8; i++) if (bit_of(r, i) == 1) res += 1 << ((i + idx) % 8);
            5: for (int i = 0; i < 8; i++) if (bit_of(r, i) == 1) res += 1 << ((i + 8 - idx) % 8);
            6: for (int i = 0; i < 8; i++) if (bit_of(r, i) == 1 && bit_of(d, i) == 1) res += 1 << i;
            default: for (int i = 0; i < 8; i++) if (bit_of(r, i) != bit_of(d, i)) res += 1 << i;
        endcase
        return res;
    endfunction

    function automatic int model_status(input int r, input int t);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 8; i++) cnt += bit_of(r, i);
        return ((r == 0) ? 128 : 0) + ((cnt % 2) * 64) + (t * 32) + cnt;
    endfunction

    initial begin
        logic [7:0] rv, sv;
        int m_r, m_t, m_stb;
        int op_i, idx_i, d_i;
        logic stb_i, view_i;

        vectors     = 0;
        miscompares = 0;

        vecs[0]  = '{3'd0, 3'd0, 8'hA5, 8'hA5, 8'h04};
        vecs[1]  = '{3'd1, 3'd1, 8'h00, 8'hA7, 8'h45};
        vecs[2]  = '{3'd2, 3'd7, 8'h00, 8'h27, 8'h24};
        vecs[3]  = '{3'd3, 3'd0, 8'h00, 8'h26, 8'h63};
        vecs[4]  = '{3'd0, 3'd0, 8'h81, 8'h81, 8'h02};
        vecs[5]  = '{3'd4, 3'd1, 8'h00, 8'h03, 8'h02};
        vecs[6]  = '{3'd5, 3'd2, 8'h00, 8'hC0, 8'h02};
        vecs[7]  = '{3'd4, 3'd0, 8'h00, 8'hC0, 8'h02};
        vecs[8]  = '{3'd6, 3'd0, 8'h0F, 8'h00, 8'h80};
        vecs[9]  = '{3'd7, 3'd3, 8'hFF, 8'hFF, 8'h08};
        vecs[10] = '{3'd2, 3'd3, 8'h00, 8'hF7, 8'h67};

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(negedge clk);
        read_views(rv, sv);
        check("reset_r", rv, 8'h00);
        check("reset_status", sv, 8'h80);
        check("uio_oe_tie", uio_oe, 8'h00);
        check("uio_out_tie", uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven single-pulse commands ----------------
        for (int i = 0; i < 11; i++) begin
            pulse_cmd(vecs[i].op, vecs[i].idx, vecs[i].d);
            read_views(rv, sv);
            check($sformatf("vec%0d_r", i), rv, vecs[i].exp_r);
            check($sformatf("vec%0d_status", i), sv, vecs[i].exp_st);
        end

        // R = F7: first-edge latency, new R visible right after the firing edge
        @(negedge clk);
        ui_in = {1'b1, 3'd3, 1'b0, 3'd0};
        @(posedge clk);
        #1 check("latency_r", uo_out, 8'hF6);
        // keep strobe high 4 more clocks: no further toggles
        repeat (4) @(posedge clk);
        #1 check("held_strobe_once", uo_out, 8'hF6);
        @(negedge clk);
        ui_in[7] = 1'b0;
        @(negedge clk);
        pulse_cmd(3'd3, 3'd0, 8'h00);
        read_views(rv, sv);
        check("rearm_toggle_back", rv, 8'hF7);

        // ena=0: strobe pulse ignored
        ena = 1'b0;
        pulse_cmd(3'd0, 3'd0, 8'h55);
        read_views(rv, sv);
        check("ena_low_ignored", rv, 8'hF7);

        // ena low with strobe high, then ena rises: stb_q was held at 0 -> fires once
        @(negedge clk);
        ui_in = {1'b1, 3'd3, 1'b0, 3'd7};
        repeat (2) @(negedge clk);
        check("ena_low_strobe_high", uo_out, 8'hF7);
        ena = 1'b1;
        @(negedge clk);
        check("ena_rise_fires", uo_out, 8'h77);
        @(negedge clk);
        check("ena_rise_once", uo_out, 8'h77);
        ui_in[7] = 1'b0;
        @(negedge clk);

        // async reset between clock edges
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_r", uo_out, 8'h00);
        ui_in[3] = 1'b1;
        #1 check("async_reset_status", uo_out, 8'h80);
        ui_in[3] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- randomized run against the reference model ----------------
        m_r = 0; m_t = 0; m_stb = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            ena    = ($urandom_range(0, 7) != 0);
            stb_i  = $urandom_range(0, 1);
            op_i   = $urandom_range(0, 7);
            idx_i  = $urandom_range(0, 7);
            d_i    = $urandom_range(0, 255);
            view_i = $urandom_range(0, 1);
            ui_in  = {stb_i, op_i[2:0], view_i, idx_i[2:0]};
            uio_in = d_i[7:0];
            #1;
            check($sformatf("rand%0d", n), uo_out,
                  view_i ? 8'(model_status(m_r, m_t)) : 8'(m_r));
            @(posedge clk);
            if (ena) begin
                if (stb_i && m_stb == 0) begin
                    m_t = bit_of(m_r, idx_i);
                    m_r = model_next(m_r, op_i, idx_i, d_i);
                end
                m_stb = stb_i;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
